// File: rtl/rtc_calendar_core.sv
// rtc_calendar_core
// Real-time clock/calendar core. A prescaler divides the input clock down to
// a once-per-second tick that advances a leap-year-aware calendar covering
// 2000-2099. A valid/ready handshake loads a new time after validating every
// field. There is a daily alarm with a configurable pulse width, and the
// core produces BCD display digits in 12- or 24-hour form.
//
// Ports
//   clk, rst           rising-edge clock, asynchronous active-low reset
//   run                1 = prescaler counts and time advances
//   mode_12h           1 = hour digits in 12-hour form
//   set_valid/ready    time-load handshake; set_* carry the new fields
//   set_err            one-cycle pulse when an accepted load was invalid
//   alarm_en/hour/min  daily alarm configuration (24-hour form)
//   alarm_fire         high for ALARM_PULSE seconds after the alarm matches
//   tick_1hz           one-cycle pulse on every second advance
//   year..second       binary time fields
//   hour_10..sec1, pm  BCD display digits and the afternoon flag
module rtc_calendar_core #(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned ALARM_PULSE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       mode_12h,
  input  logic       set_valid,
  output logic       set_ready,
  input  logic [6:0] set_year,
  input  logic [3:0] set_month,
  input  logic [4:0] set_day,
  input  logic [4:0] set_hour,
  input  logic [5:0] set_min,
  input  logic [5:0] set_sec,
  output logic       set_err,
  input  logic       alarm_en,
  input  logic [4:0] alarm_hour,
  input  logic [5:0] alarm_min,
  output logic       alarm_fire,
  output logic       tick_1hz,
  output logic [6:0] year,
  output logic [3:0] month,
  output logic [4:0] day,
  output logic [4:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic [3:0] hour_10,
  output logic [3:0] hour1,
  output logic [3:0] min_10,
  output logic [3:0] min1,
  output logic [3:0] sec_10,
  output logic [3:0] sec1,
  output logic       pm
);

  localparam int unsigned     PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [7:0]      PULSE_LEN = 8'(ALARM_PULSE);

  // February leap rule (year[1:0] == 0) is exact for 2000-2099.
  function automatic logic [4:0] days_in_month(input logic [6:0] y, input logic [3:0] m);
    logic [4:0] d;
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
      4'd2:                    d = (y[1:0] == 2'd0) ? 5'd29 : 5'd28;
      default:                 d = 5'd31;
    endcase
    return d;
  endfunction

  // Binary 0..59 to {tens, ones} BCD.
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] t;
    logic [5:0] r;
    if (v >= 6'd50) begin
      t = 4'd5; r = v - 6'd50;
    end else if (v >= 6'd40) begin
      t = 4'd4; r = v - 6'd40;
    end else if (v >= 6'd30) begin
      t = 4'd3; r = v - 6'd30;
    end else if (v >= 6'd20) begin
      t = 4'd2; r = v - 6'd20;
    end else if (v >= 6'd10) begin
      t = 4'd1; r = v - 6'd10;
    end else begin
      t = 4'd0; r = v;
    end
    return {t, r[3:0]};
  endfunction

  logic [PW-1:0] presc_q, presc_d;
  logic [6:0]    year_q, year_d;
  logic [3:0]    month_q, month_d;
  logic [4:0]    day_q, day_d;
  logic [4:0]    hour_q, hour_d;
  logic [5:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic          set_ready_q, set_ready_d;
  logic          set_err_q, set_err_d;
  logic          tick_q, tick_d;
  logic          fire_q, fire_d;
  logic [7:0]    fire_cnt_q, fire_cnt_d;

  logic          tick_s;
  logic          accept_s;
  logic          set_ok_s;
  logic          load_s;
  logic [4:0]    hour_disp_s;
  logic [7:0]    hour_bcd_s, min_bcd_s, sec_bcd_s;

  // Next-state logic: prescaler, load/tick arbitration, calendar ripple, alarm.
  always_comb begin
    presc_d     = presc_q;
    year_d      = year_q;
    month_d     = month_q;
    day_d       = day_q;
    hour_d      = hour_q;
    min_d       = min_q;
    sec_d       = sec_q;
    fire_d      = fire_q;
    fire_cnt_d  = fire_cnt_q;

    tick_s   = run && (presc_q == PRESC_MAX);
    accept_s = set_valid && set_ready_q;
    set_ok_s = (set_month >= 4'd1) && (set_month <= 4'd12) &&
               (set_day >= 5'd1) && (set_day <= days_in_month(set_year, set_month)) &&
               (set_hour < 5'd24) && (set_min < 6'd60) && (set_sec < 6'd60);
    load_s   = accept_s && set_ok_s;

    if (run) begin
      presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
    end else begin
      presc_d = presc_q;
    end

    // A valid load overrides a coincident tick and restarts the second.
    if (load_s) begin
      presc_d = '0;
      year_d  = set_year;
      month_d = set_month;
      day_d   = set_day;
      hour_d  = set_hour;
      min_d   = set_min;
      sec_d   = set_sec;
    end else if (tick_s) begin
      if (sec_q >= 6'd59) begin
        sec_d = 6'd0;
        if (min_q >= 6'd59) begin
          min_d = 6'd0;
          if (hour_q >= 5'd23) begin
            hour_d = 5'd0;
            if (day_q >= days_in_month(year_q, month_q)) begin
              day_d = 5'd1;
              if (month_q >= 4'd12) begin
                month_d = 4'd1;
                if (year_q >= 7'd99) begin
                  year_d = 7'd0;
                end else begin
                  year_d = year_q + 7'd1;
                end
              end else begin
                month_d = month_q + 4'd1;
              end
            end else begin
              day_d = day_q + 5'd1;
            end
          end else begin
            hour_d = hour_q + 5'd1;
          end
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end else begin
      sec_d = sec_q;
    end

    tick_d      = tick_s && !load_s;
    set_err_d   = accept_s && !set_ok_s;
    set_ready_d = !accept_s;

    // Alarm only reacts to real ticks, so loading the alarm time never fires it.
    if (!alarm_en) begin
      fire_d     = 1'b0;
      fire_cnt_d = 8'd0;
    end else if (tick_d) begin
      if ((hour_d == alarm_hour) && (min_d == alarm_min) && (sec_d == 6'd0)) begin
        fire_d     = 1'b1;
        fire_cnt_d = PULSE_LEN;
      end else if (fire_q) begin
        if (fire_cnt_q <= 8'd1) begin
          fire_d     = 1'b0;
          fire_cnt_d = 8'd0;
        end else begin
          fire_cnt_d = fire_cnt_q - 8'd1;
        end
      end else begin
        fire_d = 1'b0;
      end
    end else begin
      fire_d = fire_q;
    end
  end

  // State registers with asynchronous active-low reset to 2000-01-01 00:00:00.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q     <= '0;
      year_q      <= 7'd0;
      month_q     <= 4'd1;
      day_q       <= 5'd1;
      hour_q      <= 5'd0;
      min_q       <= 6'd0;
      sec_q       <= 6'd0;
      set_ready_q <= 1'b1;
      set_err_q   <= 1'b0;
      tick_q      <= 1'b0;
      fire_q      <= 1'b0;
      fire_cnt_q  <= 8'd0;
    end else begin
      presc_q     <= presc_d;
      year_q      <= year_d;
      month_q     <= month_d;
      day_q       <= day_d;
      hour_q      <= hour_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      set_ready_q <= set_ready_d;
      set_err_q   <= set_err_d;
      tick_q      <= tick_d;
      fire_q      <= fire_d;
      fire_cnt_q  <= fire_cnt_d;
    end
  end

  // Display digits: 12-hour form maps 0 -> 12 and 13..23 -> 1..11.
  always_comb begin
    if (mode_12h) begin
      if (hour_q == 5'd0) begin
        hour_disp_s = 5'd12;
      end else if (hour_q > 5'd12) begin
        hour_disp_s = hour_q - 5'd12;
      end else begin
        hour_disp_s = hour_q;
      end
    end else begin
      hour_disp_s = hour_q;
    end
    hour_bcd_s = to_bcd({1'b0, hour_disp_s});
    min_bcd_s  = to_bcd(min_q);
    sec_bcd_s  = to_bcd(sec_q);
  end

  assign set_ready  = set_ready_q;
  assign set_err    = set_err_q;
  assign tick_1hz   = tick_q;
  assign alarm_fire = fire_q;
  assign year       = year_q;
  assign month      = month_q;
  assign day        = day_q;
  assign hour       = hour_q;
  assign minute     = min_q;
  assign second     = sec_q;
  assign hour_10    = hour_bcd_s[7:4];
  assign hour1      = hour_bcd_s[3:0];
  assign min_10     = min_bcd_s[7:4];
  assign min1       = min_bcd_s[3:0];
  assign sec_10     = sec_bcd_s[7:4];
  assign sec1       = sec_bcd_s[3:0];
  assign pm         = (hour_q >= 5'd12);

endmodule

// File: tb/tb_rtc_calendar_core.sv
module tb_rtc_calendar_core;
  localparam int CLK_HZ      = 4;
  localparam int ALARM_PULSE = 2;

  logic clk = 1'b0;
  logic rst, run, mode_12h, set_valid, set_ready, set_err;
  logic [6:0] set_year;
  logic [3:0] set_month;
  logic [4:0] set_day, set_hour;
  logic [5:0] set_min, set_sec;
  logic alarm_en, alarm_fire, tick_1hz, pm;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic [6:0] year;
  logic [3:0] month;
  logic [4:0] day, hour;
  logic [5:0] minute, second;
  logic [3:0] hour_10, hour1, min_10, min1, sec_10, sec1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [32:0] exp_q[$];   // expected packed time fields
  logic [24:0] dig_q[$];   // expected {digits x6, pm}
  logic        fire_q[$];  // expected alarm_fire per cycle

  logic [32:0] obs_t;
  logic [24:0] obs_dig;
  assign obs_t   = {year, month, day, hour, minute, second};
  assign obs_dig = {hour_10, hour1, min_10, min1, sec_10, sec1, pm};

  always #5 clk = ~clk;

  rtc_calendar_core #(.CLK_HZ(CLK_HZ), .ALARM_PULSE(ALARM_PULSE)) dut (
    .clk(clk), .rst(rst), .run(run), .mode_12h(mode_12h),
    .set_valid(set_valid), .set_ready(set_ready),
    .set_year(set_year), .set_month(set_month), .set_day(set_day),
    .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
    .set_err(set_err), .alarm_en(alarm_en), .alarm_hour(alarm_hour),
    .alarm_min(alarm_min), .alarm_fire(alarm_fire), .tick_1hz(tick_1hz),
    .year(year), .month(month), .day(day), .hour(hour), .minute(minute),
    .second(second), .hour_10(hour_10), .hour1(hour1), .min_10(min_10),
    .min1(min1), .sec_10(sec_10), .sec1(sec1), .pm(pm)
  );

  function automatic logic [32:0] pack_t(input int y, input int mo, input int d,
                                         input int h, input int mi, input int s);
    return {7'(y), 4'(mo), 5'(d), 5'(h), 6'(mi), 6'(s)};
  endfunction

  // Drive one load at a negedge; returns at the negedge after the accepting edge.
  task automatic drive_load(input int y, input int mo, input int d,
                            input int h, input int mi, input int s);
    set_year  = 7'(y);
    set_month = 4'(mo);
    set_day   = 5'(d);
    set_hour  = 5'(h);
    set_min   = 6'(mi);
    set_sec   = 6'(s);
    set_valid = 1'b1;
    @(negedge clk);
    set_valid = 1'b0;
  endtask

  // Bounded wait for tick_1hz; cyc = cycles waited, or -1 if none within budget.
  task automatic wait_tick(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (tick_1hz === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int cyc;
    logic [32:0] e;
    rst = 1'b1; run = 1'b1; mode_12h = 1'b0; set_valid = 1'b0; alarm_en = 1'b0;
    alarm_hour = 5'd0; alarm_min = 6'd0;
    set_year = 7'd0; set_month = 4'd1; set_day = 5'd1; set_hour = 5'd0; set_min = 6'd0; set_sec = 6'd0;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++; if (obs_t !== pack_t(0, 1, 1, 0, 0, 0)) $display("FAIL reset_time: got %h want %h", obs_t, pack_t(0, 1, 1, 0, 0, 0)); else pass_cnt++;
    total_cnt++; if ({set_ready, set_err, tick_1hz, alarm_fire} !== 4'b1000) $display("FAIL reset_flags: got %b want 1000", {set_ready, set_err, tick_1hz, alarm_fire}); else pass_cnt++;
    total_cnt++; if (obs_dig !== 25'd0) $display("FAIL reset_digits: got %h want 0", obs_dig); else pass_cnt++;
    rst = 1'b1;
    exp_q.push_back(pack_t(0, 1, 1, 0, 0, 1));
    wait_tick(cyc);
    total_cnt++; if (cyc !== 4) $display("FAIL reset_first_tick: got %0d cycles want 4", cyc); else pass_cnt++;
    e = exp_q.pop_front();
    total_cnt++; if (obs_t !== e) $display("FAIL reset_tick_time: got %h want %h", obs_t, e); else pass_cnt++;
  endtask

  task automatic test_century();
    int cyc;
    logic [32:0] e;
    drive_load(99, 12, 31, 23, 59, 59);
    exp_q.push_back(pack_t(0, 1, 1, 0, 0, 0));
    wait_tick(cyc);
    total_cnt++; if (cyc !== 4) $display("FAIL century_latency: got %0d want 4", cyc); else pass_cnt++;
    e = exp_q.pop_front();
    total_cnt++; if (obs_t !== e) $display("FAIL century_time: got %h want %h", obs_t, e); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (tick_1hz !== 1'b0) $display("FAIL century_tick_width: got %b want 0", tick_1hz); else pass_cnt++;
  endtask

  task automatic test_month_end();
    int ld [3][6] = '{'{24, 2, 28, 23, 59, 59}, '{23, 2, 28, 23, 59, 59}, '{23, 4, 30, 23, 59, 59}};
    int ex [3][6] = '{'{24, 2, 29, 0, 0, 0},    '{23, 3, 1, 0, 0, 0},      '{23, 5, 1, 0, 0, 0}};
    int cyc;
    logic [32:0] e;
    for (int k = 0; k < 3; k++) begin
      drive_load(ld[k][0], ld[k][1], ld[k][2], ld[k][3], ld[k][4], ld[k][5]);
      exp_q.push_back(pack_t(ex[k][0], ex[k][1], ex[k][2], ex[k][3], ex[k][4], ex[k][5]));
      wait_tick(cyc);
      total_cnt++; if (cyc !== 4) $display("FAIL month_end_latency[%0d]: got %0d want 4", k, cyc); else pass_cnt++;
      e = exp_q.pop_front();
      total_cnt++; if (obs_t !== e) $display("FAIL month_end_time[%0d]: got %h want %h", k, obs_t, e); else pass_cnt++;
    end
  endtask

  task automatic test_invalid();
    int bad [2][6] = '{'{23, 2, 29, 12, 0, 0}, '{23, 13, 1, 12, 0, 0}};
    logic [32:0] e;
    for (int k = 0; k < 2; k++) begin
      drive_load(22, 6, 15, 9, 10, 20);
      @(negedge clk);
      exp_q.push_back(pack_t(22, 6, 15, 9, 10, 20));
      drive_load(bad[k][0], bad[k][1], bad[k][2], bad[k][3], bad[k][4], bad[k][5]);
      e = exp_q.pop_front();
      total_cnt++; if (obs_t !== e) $display("FAIL invalid_time[%0d]: got %h want %h", k, obs_t, e); else pass_cnt++;
      total_cnt++; if ({set_err, set_ready} !== 2'b10) $display("FAIL invalid_err_ready[%0d]: got %b want 10", k, {set_err, set_ready}); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if ({set_err, set_ready} !== 2'b01) $display("FAIL invalid_recover[%0d]: got %b want 01", k, {set_err, set_ready}); else pass_cnt++;
    end
  endtask

  task automatic test_12h();
    // {hour, mode_12h, hour_10, hour1, pm}
    int tbl [5][5] = '{'{0, 1, 1, 2, 0}, '{13, 1, 0, 1, 1}, '{12, 1, 1, 2, 1}, '{13, 0, 1, 3, 1}, '{11, 1, 1, 1, 0}};
    logic [24:0] e;
    for (int k = 0; k < 5; k++) begin
      mode_12h = tbl[k][1][0];
      dig_q.push_back({4'(tbl[k][2]), 4'(tbl[k][3]), 4'd4, 4'd7, 4'd2, 4'd5, 1'(tbl[k][4])});
      drive_load(30, 7, 4, tbl[k][0], 47, 25);
      e = dig_q.pop_front();
      total_cnt++; if (obs_dig !== e) $display("FAIL digits[%0d]: got %h want %h", k, obs_dig, e); else pass_cnt++;
      @(negedge clk);
    end
    mode_12h = 1'b0;
  endtask

  task automatic test_alarm();
    int cyc;
    logic ef;
    alarm_hour = 5'd7; alarm_min = 6'd30; alarm_en = 1'b1;
    drive_load(25, 3, 3, 7, 29, 59);
    for (int i = 1; i <= 13; i++) fire_q.push_back((i >= 4) && (i <= 11));
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk);
      ef = fire_q.pop_front();
      total_cnt++; if (alarm_fire !== ef) $display("FAIL alarm_pulse[cycle %0d]: got %b want %b", i, alarm_fire, ef); else pass_cnt++;
    end
    drive_load(25, 3, 3, 7, 30, 0);
    for (int i = 1; i <= 6; i++) begin
      total_cnt++; if (alarm_fire !== 1'b0) $display("FAIL alarm_load_nofire[cycle %0d]: got %b want 0", i, alarm_fire); else pass_cnt++;
      @(negedge clk);
    end
    drive_load(25, 3, 3, 7, 29, 59);
    wait_tick(cyc);
    total_cnt++; if ((cyc !== 4) || (alarm_fire !== 1'b1)) $display("FAIL alarm_retrigger: got cyc %0d fire %b want 4/1", cyc, alarm_fire); else pass_cnt++;
    alarm_en = 1'b0;
    @(negedge clk);
    total_cnt++; if (alarm_fire !== 1'b0) $display("FAIL alarm_disable: got %b want 0", alarm_fire); else pass_cnt++;
  endtask

  task automatic test_run_hold();
    int cyc;
    logic [32:0] e;
    drive_load(21, 1, 1, 0, 0, 0);
    repeat (3) @(negedge clk);
    run = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      total_cnt++; if ((tick_1hz !== 1'b0) || (obs_t !== pack_t(21, 1, 1, 0, 0, 0))) $display("FAIL run_hold[%0d]: got tick %b time %h want 0/%h", i, tick_1hz, obs_t, pack_t(21, 1, 1, 0, 0, 0)); else pass_cnt++;
    end
    run = 1'b1;
    exp_q.push_back(pack_t(21, 1, 1, 0, 0, 1));
    @(negedge clk);
    e = exp_q.pop_front();
    total_cnt++; if ((tick_1hz !== 1'b1) || (obs_t !== e)) $display("FAIL run_resume: got tick %b time %h want 1/%h", tick_1hz, obs_t, e); else pass_cnt++;
    wait_tick(cyc);
    total_cnt++; if (cyc !== 4) $display("FAIL run_next_tick: got %0d want 4", cyc); else pass_cnt++;
  endtask

  task automatic test_collision();
    int cyc;
    logic [32:0] e;
    drive_load(20, 1, 1, 10, 0, 0);
    repeat (3) @(negedge clk);
    exp_q.push_back(pack_t(20, 8, 8, 8, 8, 8));
    drive_load(20, 8, 8, 8, 8, 8);
    e = exp_q.pop_front();
    total_cnt++; if ((obs_t !== e) || (tick_1hz !== 1'b0)) $display("FAIL collision_load: got time %h tick %b want %h/0", obs_t, tick_1hz, e); else pass_cnt++;
    exp_q.push_back(pack_t(20, 8, 8, 8, 8, 9));
    wait_tick(cyc);
    e = exp_q.pop_front();
    total_cnt++; if ((cyc !== 4) || (obs_t !== e)) $display("FAIL collision_next_tick: got cyc %0d time %h want 4/%h", cyc, obs_t, e); else pass_cnt++;
    @(negedge clk);
    drive_load(5, 5, 5, 5, 5, 5);
    rst = 1'b0;
    #1;
    total_cnt++; if (obs_t !== pack_t(0, 1, 1, 0, 0, 0)) $display("FAIL midrun_reset_time: got %h want %h", obs_t, pack_t(0, 1, 1, 0, 0, 0)); else pass_cnt++;
    total_cnt++; if ({set_ready, set_err, tick_1hz, alarm_fire} !== 4'b1000) $display("FAIL midrun_reset_flags: got %b want 1000", {set_ready, set_err, tick_1hz, alarm_fire}); else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_century();
    test_month_end();
    test_invalid();
    test_12h();
    test_alarm();
    test_run_hold();
    test_collision();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/rtc_calendar_core.md
# rtc_calendar_core

Parametrised real-time clock/calendar core for the watch design. It replaces the fixed-rate time counter with a prescaled second tick derived from any clock frequency, and adds a full leap-year-aware calendar, a validated time-set handshake, a 12/24-hour display mode and a daily alarm. Its BCD digit outputs feed the LCD string generator directly, and its binary fields feed any other consumer.

## Interface
- CLK_HZ, 50_000_000, input clock frequency in Hz; the prescaler period is CLK_HZ cycles, and CLK_HZ must be at least 2.
- ALARM_PULSE, 1, width of the alarm_fire pulse in seconds (1..255).
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- run  in  1  1 = time advances; 0 = prescaler and time hold.
- mode_12h  in  1  1 = digit outputs in 12-hour form; 0 = 24-hour form.
- set_valid  in  1  time-load request.
- set_ready  out  1  core can accept a load.
- set_year  in  7  years since 2000 (0..99).
- set_month  in  4  month (1..12).
- set_day  in  5  day of month (1..31).
- set_hour  in  5  hour (0..23).
- set_min  in  6  minute (0..59).
- set_sec  in  6  second (0..59).
- set_err  out  1  one-cycle pulse: the accepted load was invalid.
- alarm_en  in  1  alarm enable.
- alarm_hour  in  5  alarm hour (0..23, 24-hour form).
- alarm_min  in  6  alarm minute.
- alarm_fire  out  1  alarm pulse.
- tick_1hz  out  1  one-cycle pulse on each second advance.
- year  out  7  binary time fields.
- month  out  4  binary time fields.
- day  out  5  binary time fields.
- hour  out  5  binary time fields, 0..23.
- minute  out  6  binary time fields.
- second  out  6  binary time fields.
- hour_10, hour1, min_10, min1, sec_10, sec1  out  4 each  BCD display digits.
- pm  out  1  1 when hour ≥ 12, in either mode.

## Operation
- **Reset values:** 2000-01-01 00:00:00 (year 0, month 1, day 1), prescaler 0, set_ready 1, and set_err, tick_1hz and alarm_fire all 0.
- **Prescaler:**
  - Counts 0..CLK_HZ-1 while run = 1.
  - At CLK_HZ-1 it wraps to 0 and raises an internal tick.
  - When run = 0 it holds its value.
- **On a tick:**
  - second increments.
  - The carry ripples through minute (60), hour (24), day (days-in-month), month (12) and year (100) in the same cycle.
  - Year 99 rolls over to 0.
- **Days-in-month:**
  - Months 4, 6, 9 and 11 have 30 days.
  - February has 29 days when year[1:0] == 0, otherwise 28. This rule is exact for 2000–2099.
  - All other months have 31 days.
- **Set handshake:**
  - A load is accepted when set_valid && set_ready.
  - Validation checks month 1..12, day 1..days-in-month(set_year, set_month), hour < 24, min < 60 and sec < 60.
  - Valid load: all fields are loaded at the next edge and the prescaler is cleared to 0.
  - Invalid load: set_err pulses for one cycle and no state changes.
  - In both cases set_ready is 0 for the one cycle after acceptance, then returns to 1.
- **Set vs. tick:** a valid load wins over a tick in the same cycle. The tick is discarded and tick_1hz stays 0.
- **Alarm:**
  - Triggers when alarm_en = 1 and a tick produces hour = alarm_hour, minute = alarm_min and second = 0.
  - On trigger, alarm_fire goes high for ALARM_PULSE seconds (ALARM_PULSE ticks).
  - Loading a time never triggers the alarm.
  - Deasserting alarm_en clears alarm_fire at the next edge.
- **Display digits:** combinational from the registered hour, minute and second.
  - 24-hour mode: the hour digits are hour as two BCD digits.
  - 12-hour mode: hour 0 → 12, 1..12 → unchanged, 13..23 → hour-12.
  - Minute and second digits are the same in both modes.

## Timing
- The tick occurs on the edge where the prescaler goes from CLK_HZ-1 to 0. On that same edge, the time fields update and tick_1hz goes to 1 for one cycle.
- Time changes at most once per CLK_HZ cycles. The first tick after reset or after a load comes exactly CLK_HZ cycles later.
- Set latency is one cycle: the new fields are visible the cycle after acceptance. set_err is asserted in that same cycle.
- alarm_fire rises on the triggering tick edge and falls on the edge of the ALARM_PULSE-th following tick.
- Asserting rst mid-operation immediately forces all reset values, including the alarm and handshake state.
- run = 0 during the prescaler's terminal count suppresses the tick. Counting resumes from the held count.

## Test plan
All scenarios use CLK_HZ = 4.
- **Century rollover:** load 99-12-31 23:59:59, then wait 4 cycles → 00-01-01 00:00:00 and tick_1hz = 1 for one cycle.
- **Leap year:** load 24-02-28 23:59:59 → 24-02-29 00:00:00. Load 23-02-28 23:59:59 → 23-03-01 00:00:00.
- **Invalid load:** load 23-02-29 12:00:00 → set_err pulses, time is unchanged, and set_ready is low for 1 cycle. Load month 13 → same response.
- **12-hour display:** hour 0 with mode_12h = 1 → digits 1,2 and pm = 0. Hour 13 → digits 0,1 and pm = 1. Hour 12 → digits 1,2 and pm = 1. Same hour 13 with mode_12h = 0 → digits 1,3.
- **Alarm:**
  - Alarm 07:30, ALARM_PULSE = 2, load 07:29:59 → alarm_fire is high for 8 cycles starting at 07:30:00.
  - Loading 07:30:00 directly → no fire.
- **Set vs. tick collision:** assert set_valid on the prescaler's terminal-count cycle → loaded values win, no tick_1hz, and the next tick comes 4 cycles later. Also assert rst mid-count → outputs at reset values.
